// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_ctrl_pkg                                                         |
// | Shared widths, dout_tdata field bounds and FSM encoding for div_ctrl.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_ctrl_pkg;

    localparam int DIV_W  = 32;
    localparam int DOUT_W = 2 * DIV_W;

    // dout_tdata layout: quotient in the upper half, remainder in the lower half
    localparam int QUO_HI = 63;
    localparam int QUO_LO = 32;
    localparam int REM_HI = 31;
    localparam int REM_LO = 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

endpackage
`default_nettype wire

// File: rtl/div_chan_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_chan_issue                                                       |
// | Holds one AXI-stream tvalid until accepted and remembers completion. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_chan_issue (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_tready,
    output logic o_tvalid,
    output logic o_done
);

    logic r_tvalid;
    logic r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tvalid <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_tvalid <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_tvalid && i_tready) begin
            r_tvalid <= 1'b0;
            r_done   <= 1'b1;
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_ctrl                                                             |
// | Feeds a signed or unsigned divider IP and returns its result.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_signed,
    input  logic [DIV_W-1:0]    req_dividend,
    input  logic [DIV_W-1:0]    req_divisor,
    input  logic                cancel,
    output logic                busy,
    output logic [DIV_W-1:0]    div_dividend,
    output logic [DIV_W-1:0]    div_divisor,
    output logic                divs_dividend_tvalid,
    output logic                divs_divisor_tvalid,
    output logic                divu_dividend_tvalid,
    output logic                divu_divisor_tvalid,
    input  logic                divs_dividend_tready,
    input  logic                divs_divisor_tready,
    input  logic                divu_dividend_tready,
    input  logic                divu_divisor_tready,
    input  logic                divs_dout_tvalid,
    input  logic [DOUT_W-1:0]   divs_dout_tdata,
    input  logic                divu_dout_tvalid,
    input  logic [DOUT_W-1:0]   divu_dout_tdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DIV_W-1:0]    res_quotient,
    output logic [DIV_W-1:0]    res_remainder
);

    logic [2:0]         r_state;
    logic               r_cancelled;
    logic               r_signed;
    logic [DIV_W-1:0]   r_dividend;
    logic [DIV_W-1:0]   r_divisor;
    logic [DIV_W-1:0]   r_quotient;
    logic [DIV_W-1:0]   r_remainder;

    logic               w_accept;
    logic               w_dvd_tvalid;
    logic               w_dvd_done;
    logic               w_dvd_tready;
    logic               w_dvs_tvalid;
    logic               w_dvs_done;
    logic               w_dvs_tready;
    logic               w_both_done;
    logic               w_dout_valid;
    logic [DOUT_W-1:0]  w_dout_data;

    assign req_ready = (r_state == S_IDLE) && !cancel;
    assign w_accept  = req_valid && req_ready;

    // Only the selected IP's handshakes and results are ever looked at
    assign w_dvd_tready = r_signed ? divs_dividend_tready : divu_dividend_tready;
    assign w_dvs_tready = r_signed ? divs_divisor_tready  : divu_divisor_tready;
    assign w_dout_valid = r_signed ? divs_dout_tvalid     : divu_dout_tvalid;
    assign w_dout_data  = r_signed ? divs_dout_tdata      : divu_dout_tdata;

    div_chan_issue u_dvd_chan (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_accept),
        .i_tready (w_dvd_tready),
        .o_tvalid (w_dvd_tvalid),
        .o_done   (w_dvd_done)
    );

    div_chan_issue u_dvs_chan (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_accept),
        .i_tready (w_dvs_tready),
        .o_tvalid (w_dvs_tvalid),
        .o_done   (w_dvs_done)
    );

    // A channel counts as complete in the same cycle its handshake fires
    assign w_both_done = (w_dvd_done || (w_dvd_tvalid && w_dvd_tready)) &&
                         (w_dvs_done || (w_dvs_tvalid && w_dvs_tready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cancelled <= 1'b0;
            r_signed    <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_ISSUE;
                        r_cancelled <= 1'b0;
                        r_signed    <= req_signed;
                        r_dividend  <= req_dividend;
                        r_divisor   <= req_divisor;
                    end
                end
                S_ISSUE: begin
                    if (cancel) begin
                        r_cancelled <= 1'b1;
                    end
                    if (w_both_done) begin
                        r_cancelled <= 1'b0;
                        r_state     <= (r_cancelled || cancel) ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_dout_valid) begin
                        if (cancel) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_quotient  <= w_dout_data[QUO_HI:QUO_LO];
                            r_remainder <= w_dout_data[REM_HI:REM_LO];
                            r_state     <= S_DONE;
                        end
                    end else if (cancel) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (cancel || res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_dout_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy                 = (r_state != S_IDLE);
    assign res_valid            = (r_state == S_DONE);
    assign res_quotient         = r_quotient;
    assign res_remainder        = r_remainder;
    assign div_dividend         = r_dividend;
    assign div_divisor          = r_divisor;
    assign divs_dividend_tvalid = w_dvd_tvalid &&  r_signed;
    assign divs_divisor_tvalid  = w_dvs_tvalid &&  r_signed;
    assign divu_dividend_tvalid = w_dvd_tvalid && !r_signed;
    assign divu_divisor_tvalid  = w_dvs_tvalid && !r_signed;

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, result width 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  EXE stage presents a divide op; held until accepted.
REQ-005 req_ready  output  1  controller accepts the request this cycle.
REQ-006 req_signed  input  1  1 = signed divider, 0 = unsigned divider.
REQ-007 req_dividend / req_divisor  input  32 each  operands, sampled on accept.
REQ-008 cancel  input  1  EXE flush; abandon current op.
REQ-009 busy  output  1  state != IDLE.
REQ-010 div_dividend / div_divisor  output  32 each  latched operands, shared by both dividers.
REQ-011 {divs,divu}_dividend_tvalid, {divs,divu}_divisor_tvalid  output  1 each  per-IP, per-channel valid.
REQ-012 {divs,divu}_dividend_tready, {divs,divu}_divisor_tready  input  1 each  per-channel ready.
REQ-013 {divs,divu}_dout_tvalid  input  1 each; {divs,divu}_dout_tdata  input  64 each; [63:32] quotient, [31:0] remainder.
REQ-014 res_valid  output  1; res_ready  input  1; res_quotient / res_remainder  output  32 each.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, DONE and DRAIN, with a cancelled flag used only in ISSUE.
REQ-016 req_ready SHALL be 1 only in IDLE with cancel=0; accept = req_valid & req_ready -> latch operands and sign, go ISSUE next cycle.
REQ-017 In ISSUE, both tvalids of the selected IP SHALL be 1 from the first ISSUE cycle; the other IP's tvalids SHALL stay 0.
REQ-018 Each channel's tvalid SHALL drop the cycle after tvalid&tready are both high; the channels complete independently, in either order or together.
REQ-019 Once both channels have completed, the block SHALL go to WAIT, or to DRAIN if the cancelled flag is set.
REQ-020 In WAIT, the selected IP's dout_tvalid SHALL capture quotient/remainder and go DONE; the non-selected IP's dout_tvalid SHALL be ignored in every state.
REQ-021 DONE SHALL hold res_valid=1 with stable data until res_ready=1, then go IDLE; min latency accept->res_valid = 2 cycles + IP latency.
REQ-022 cancel in IDLE SHALL have no effect and block any acceptance that cycle.
REQ-023 cancel in ISSUE SHALL set the flag and keep unaccepted channels valid until they are accepted, so the IP is never left half-fed.
REQ-024 cancel in WAIT: no dout_tvalid that cycle -> DRAIN; with dout_tvalid that cycle -> discard the result and go IDLE.
REQ-025 In DRAIN, the selected dout_tvalid SHALL be discarded and the block SHALL go IDLE; cancel is ignored in DRAIN.
REQ-026 cancel in DONE SHALL deassert res_valid next cycle and go IDLE without res_ready; cancel beats res_ready in the same cycle.
REQ-027 Divide-by-zero and overflow (0x80000000 / -1) SHALL be passed through unmodified; the controller does not special-case them.

Reset
REQ-028 reset SHALL force IDLE asynchronously and clear the cancelled flag; all tvalids, res_valid and busy become 0; req_ready becomes 1.
REQ-029 Latched operands and result registers SHALL reset to 0.
REQ-030 Reset mid-operation SHALL abandon the op; a later dout_tvalid arriving in IDLE SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the state encoding, DIV_W=32, and the quotient/remainder field bounds of dout_tdata.
REQ-032 One sub-module, div_chan_issue (a single tvalid/tready holder with done flag), SHALL be instantiated twice, for the dividend and divisor channels.

Verification
REQ-033 Signed 0xFFFFFFF9 / 0x00000002 with both treadys high and dout after 8 cycles -> divs tvalids pulse for 1 cycle, divu untouched, res quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-034 Unsigned 100/7 with divisor tready delayed 3 cycles after dividend -> dividend tvalid drops after 1 cycle, divisor tvalid held 4 cycles, result 14 / 2.
REQ-035 cancel in ISSUE with divisor not yet accepted -> divisor tvalid held until accept, DRAIN entered, IP result discarded, res_valid never 1, busy low after dout.
REQ-036 res_ready held low 5 cycles in DONE -> res_valid and data stable for 5 cycles, req_ready=0 throughout, IDLE the cycle after res_ready.
REQ-037 Async reset asserted mid-WAIT, then dout_tvalid arrives -> outputs clear immediately, no res_valid, next request 9/3 completes with 3/0.
REQ-038 cancel with req_valid in IDLE -> no accept; cancel with dout_tvalid in WAIT -> IDLE next cycle, no res_valid.
